// File: rtl/trail_pkg.sv
// trail_pkg: shared field widths, colour-space coefficients and pixel types for the trail decoder.
package trail_pkg;
  localparam int Y_BITS_DEF  = 4;
  localparam int CR_BITS_DEF = 2;
  localparam int CB_BITS_DEF = 2;
  localparam int K_R_CR      = 359;
  localparam int K_G_CB      = 88;
  localparam int K_G_CR      = 183;
  localparam int K_B_CB      = 454;
  localparam int CHROMA_OFS  = 128;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
  function automatic logic signed [17:0] sx10(input logic [9:0] x);
    return {{8{x[9]}}, x};
  endfunction
  function automatic logic [17:0] mul_k(input logic [9:0] c, input int k);
    return 18'(sx10(c) * $signed(18'(k)));
  endfunction
  function automatic logic [7:0] clamp8(input logic [17:0] x);
    return x[17] ? 8'd0 : |x[16:8] ? 8'hFF : x[7:0];
  endfunction
endpackage

// File: rtl/trail_code_expand.sv
// trail_code_expand: widens an N-bit code to an 8-bit luma replica or a signed chroma offset.
module trail_code_expand import trail_pkg::*; #(
  parameter int N      = 2,
  parameter bit CHROMA = 1'b1
) (
  input  logic [N-1:0] code,
  output logic [9:0]   val
);
  logic [7:0] rep;
  logic [7:0] c8;
  always_comb begin
    rep = '0;
    for (int i = 0; i < 8; i++) rep[7-i] = code[N-1-(i%N)];
    c8 = 8'({code, 1'b1}) << (7 - N);
    // chroma lands mid-bucket, then is re-centred around zero
    val = CHROMA ? {2'b00, c8} - 10'(CHROMA_OFS) : {2'b00, rep};
  end
endmodule

// File: rtl/trail_unpack_rgb.sv
// trail_unpack_rgb: expands packed {Y,Cr,Cb} trail-history pixels to RGB888 with raster tags,
// as a 3-stage valid/ready pipeline sharing one global advance enable.
module trail_unpack_rgb import trail_pkg::*; #(
  parameter int Y_BITS      = Y_BITS_DEF,
  parameter int CR_BITS     = CR_BITS_DEF,
  parameter int CB_BITS     = CB_BITS_DEF,
  parameter int COLOR_DEPTH = Y_BITS_DEF + CR_BITS_DEF + CB_BITS_DEF,
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 180
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [COLOR_DEPTH-1:0]      pixel_in,
  input  logic                        sof_in,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic [23:0]                 rgb_out,
  output logic [$clog2(H_ACTIVE)-1:0] hcount_out,
  output logic [$clog2(V_ACTIVE)-1:0] vcount_out,
  output logic                        last_out
);
  localparam int HW = $clog2(H_ACTIVE);
  localparam int VW = $clog2(V_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);
  typedef struct packed {
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          last;
  } tag_t;
  typedef struct packed {
    logic [9:0]  y;
    logic [17:0] pr;
    logic [17:0] pgb;
    logic [17:0] pgr;
    logic [17:0] pb;
    tag_t        tag;
  } s1_t;
  typedef struct packed {
    logic [17:0] r;
    logic [17:0] g;
    logic [17:0] b;
    tag_t        tag;
  } s2_t;
  typedef struct packed {
    rgb888_t rgb;
    tag_t    tag;
  } out_t;
  logic [9:0] y_v, cr_v, cb_v;
  logic en, acc;
  tag_t tag;
  logic [HW-1:0] hc_d, hc_q;
  logic [VW-1:0] vc_d, vc_q;
  logic v1_q, v2_q, v3_q;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  out_t out_d, out_q;
  trail_code_expand #(.N(Y_BITS), .CHROMA(1'b0)) u_y (
    .code(pixel_in[COLOR_DEPTH-1 -: Y_BITS]),
    .val (y_v)
  );
  trail_code_expand #(.N(CR_BITS), .CHROMA(1'b1)) u_cr (
    .code(pixel_in[CB_BITS +: CR_BITS]),
    .val (cr_v)
  );
  trail_code_expand #(.N(CB_BITS), .CHROMA(1'b1)) u_cb (
    .code(pixel_in[CB_BITS-1:0]),
    .val (cb_v)
  );
  // a sof pixel is its own tag origin; the counter then continues from it
  always_comb begin
    en = !v3_q || ready_out;
    acc = valid_in && en;
    tag.h = sof_in ? '0 : hc_q;
    tag.v = sof_in ? '0 : vc_q;
    tag.last = tag.h == H_LAST && tag.v == V_LAST;
    hc_d = !acc ? hc_q : tag.h == H_LAST ? '0 : tag.h + 1'b1;
    vc_d = !acc ? vc_q : tag.h != H_LAST ? tag.v : tag.v == V_LAST ? '0 : tag.v + 1'b1;
  end
  always_comb begin
    s1_d = '{y: y_v, pr: mul_k(cr_v, K_R_CR), pgb: mul_k(cb_v, K_G_CB),
             pgr: mul_k(cr_v, K_G_CR), pb: mul_k(cb_v, K_B_CB), tag: tag};
    s2_d.r = sx10(s1_q.y) + ($signed(s1_q.pr) >>> 8);
    s2_d.g = sx10(s1_q.y) - (($signed(s1_q.pgb) + $signed(s1_q.pgr)) >>> 8);
    s2_d.b = sx10(s1_q.y) + ($signed(s1_q.pb) >>> 8);
    s2_d.tag = s1_q.tag;
    out_d = '{rgb: '{r: clamp8(s2_q.r), g: clamp8(s2_q.g), b: clamp8(s2_q.b)}, tag: s2_q.tag};
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      out_q <= '0;
      hc_q <= '0;
      vc_q <= '0;
    end else if (en) begin
      v1_q <= valid_in;
      v2_q <= v1_q;
      v3_q <= v2_q;
      s1_q <= s1_d;
      s2_q <= s2_d;
      out_q <= out_d;
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end
  assign ready_in = en;
  assign valid_out = v3_q;
  assign rgb_out = out_q.rgb;
  assign hcount_out = out_q.tag.h;
  assign vcount_out = out_q.tag.v;
  assign last_out = out_q.tag.last;
endmodule

// File: tb/tb_trail_unpack_rgb.sv
// tb_trail_unpack_rgb: directed vector table plus scoreboarded streams for the trail RGB decoder.
module tb_trail_unpack_rgb;
  localparam int H = 320;
  localparam int V = 180;
  typedef struct packed {
    logic [23:0] rgb;
    logic [8:0]  h;
    logic [7:0]  v;
    logic        last;
  } exp_t;
  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    exp_t       e;
  } vec_t;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic valid_in = 1'b0;
  logic sof_in = 1'b0;
  logic ready_out = 1'b1;
  logic [7:0] pixel_in = '0;
  logic ready_in, valid_out, last_out;
  logic [23:0] rgb_out;
  logic [8:0] hcount_out;
  logic [7:0] vcount_out;
  int checks = 0;
  int errors = 0;
  int mh = 0;
  int mv = 0;
  int th, tv;
  int n_last = 0;
  bit stalled = 1'b0;
  exp_t held, e;
  exp_t q[$];
  vec_t tvec[8];

  trail_unpack_rgb dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_in(ready_in),
    .pixel_in(pixel_in), .sof_in(sof_in), .valid_out(valid_out), .ready_out(ready_out),
    .rgb_out(rgb_out), .hcount_out(hcount_out), .vcount_out(vcount_out), .last_out(last_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] p, input int h, input int v);
    int y, cr, cb, r, g, b;
    y = int'(p[7:4]) * 17;
    cr = int'(p[3:2]) * 64 + 32 - 128;
    cb = int'(p[1:0]) * 64 + 32 - 128;
    r = y + ((359 * cr) >>> 8);
    g = y - ((88 * cb + 183 * cr) >>> 8);
    b = y + ((454 * cb) >>> 8);
    r = r < 0 ? 0 : r > 255 ? 255 : r;
    g = g < 0 ? 0 : g > 255 ? 255 : g;
    b = b < 0 ? 0 : b > 255 ? 255 : b;
    return {8'(r), 8'(g), 8'(b), 9'(h), 8'(v), (h == H - 1 && v == V - 1)};
  endfunction

  // Monitor: scoreboard on output handshakes, stall stability, ready_in, input acceptance
  initial forever begin
    @(negedge clk_in);
    if (rst_in) stalled = 1'b0;
    else begin
      if (stalled) begin
        chk("stall_valid", valid_out, 1);
        chk("stall_hold", {rgb_out, hcount_out, vcount_out, last_out}, held);
      end
      if (valid_out && ready_out) begin
        chk("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("out_rgb", rgb_out, e.rgb);
          chk("out_h", hcount_out, e.h);
          chk("out_v", vcount_out, e.v);
          chk("out_last", last_out, e.last);
          if (last_out) n_last++;
        end
      end
      stalled = valid_out && !ready_out;
      held = {rgb_out, hcount_out, vcount_out, last_out};
      chk("ready_in", ready_in, !valid_out || ready_out);
      if (valid_in && ready_in) begin
        th = sof_in ? 0 : mh;
        tv = sof_in ? 0 : mv;
        q.push_back(model(pixel_in, th, tv));
        mh = th == H - 1 ? 0 : th + 1;
        mv = th != H - 1 ? tv : tv == V - 1 ? 0 : tv + 1;
      end
    end
  end

  task automatic send(input logic [7:0] p, input logic s, input bit rnd);
    bit acc = 1'b0;
    int n = 0;
    valid_in = 1'b1;
    pixel_in = p;
    sof_in = s;
    do begin
      if (rnd) ready_out = 1'($urandom_range(0, 1));
      @(negedge clk_in);
      acc = ready_in;
      @(posedge clk_in);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_bound", acc, 1);
    valid_in = 1'b0;
    sof_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      sof_in = 1'($urandom_range(0, 1));
      ready_out = 1'($urandom_range(0, 1));
      @(posedge clk_in);
      #1;
    end
    sof_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ready_out = 1'b1;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic send_check(input string nm, input logic [7:0] p, input logic s, input exp_t x);
    send(p, s, 1'b0);
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    chk({nm, "_valid"}, valid_out, 1);
    chk({nm, "_rgb"}, rgb_out, x.rgb);
    chk({nm, "_h"}, hcount_out, x.h);
    chk({nm, "_v"}, vcount_out, x.v);
    chk({nm, "_last"}, last_out, x.last);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nl0;
    tvec[0] = '{pix: 8'h8A, sof: 1'b1, e: {8'd180, 8'd103, 8'd192, 9'd0, 8'd0, 1'b0}};
    tvec[1] = '{pix: 8'hF5, sof: 1'b0, e: {8'd210, 8'd255, 8'd198, 9'd1, 8'd0, 1'b0}};
    tvec[2] = '{pix: 8'h00, sof: 1'b0, e: {8'd0,   8'd102, 8'd0,   9'd2, 8'd0, 1'b0}};
    tvec[3] = '{pix: 8'hFF, sof: 1'b0, e: {8'd255, 8'd154, 8'd255, 9'd3, 8'd0, 1'b0}};
    tvec[4] = '{pix: 8'h40, sof: 1'b0, e: {8'd0,   8'd170, 8'd0,   9'd4, 8'd0, 1'b0}};
    tvec[5] = '{pix: 8'h7C, sof: 1'b0, e: {8'd253, 8'd84,  8'd0,   9'd5, 8'd0, 1'b0}};
    tvec[6] = '{pix: 8'h93, sof: 1'b0, e: {8'd18,  8'd189, 8'd255, 9'd6, 8'd0, 1'b0}};
    tvec[7] = '{pix: 8'hC6, sof: 1'b1, e: {8'd159, 8'd216, 8'd255, 9'd0, 8'd0, 1'b0}};
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_valid", valid_out, 0);
    chk("rst_rgb", rgb_out, 0);
    chk("rst_h", hcount_out, 0);
    chk("rst_v", vcount_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_ready", ready_in, 1);
    @(posedge clk_in);
    #1;
    foreach (tvec[i]) send_check($sformatf("vec%0d", i), tvec[i].pix, tvec[i].sof, tvec[i].e);
    // full frame: last_out exactly once, on (319,179), then wrap to (0,0)
    nl0 = n_last;
    send(8'($urandom), 1'b1, 1'b0);
    for (int i = 1; i < H * V - 1; i++) send(8'($urandom), 1'b0, 1'b0);
    send_check("frame_end", 8'h8A, 1'b0, {8'd180, 8'd103, 8'd192, 9'd319, 8'd179, 1'b1});
    send_check("frame_wrap", 8'h8A, 1'b0, {8'd180, 8'd103, 8'd192, 9'd0, 8'd0, 1'b0});
    drain();
    chk("frame_last_count", n_last - nl0, 1);
    // sof arriving where the counter sits at (5,2)
    send(8'($urandom), 1'b1, 1'b0);
    for (int i = 1; i < 2 * H + 5; i++) send(8'($urandom), 1'b0, 1'b0);
    send_check("midsof", 8'h8A, 1'b1, {8'd180, 8'd103, 8'd192, 9'd0, 8'd0, 1'b0});
    send_check("midsof_next", 8'h8A, 1'b0, {8'd180, 8'd103, 8'd192, 9'd1, 8'd0, 1'b0});
    drain();
    // random backpressure and bubbles, with sof also toggled during bubbles
    for (int i = 0; i < 1000; i++) begin
      send(8'($urandom), 1'($urandom_range(0, 15) == 0), 1'b1);
      idle(int'($urandom_range(0, 2)));
    end
    drain();
    // reset with three pixels in flight
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b0);
    rst_in = 1'b1;
    q.delete();
    mh = 0;
    mv = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_rgb", rgb_out, 0);
    chk("midrst_h", hcount_out, 0);
    chk("midrst_v", vcount_out, 0);
    chk("midrst_last", last_out, 0);
    chk("midrst_ready", ready_in, 1);
    repeat (5) begin
      @(negedge clk_in);
      chk("midrst_no_out", valid_out, 0);
    end
    @(posedge clk_in);
    #1;
    send_check("post_rst", 8'h8A, 1'b0, {8'd180, 8'd103, 8'd192, 9'd0, 8'd0, 1'b0});
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
